kbd_scancode_decoder: RTL

Consumes the byte stream produced by the PS2 serial-to-parallel converter (ParallelData / ParallelDataReady, KbdClk domain) and turns it into ASCII characters in the core clock domain. It synchronises the ready strobe and tracks make, break (F0) and extended (E0) prefixes. It also tracks Shift and CapsLock state and pushes printable characters into a small FIFO that the core pops with a read-enable.

---
 rtl/kbd_scancode_decoder.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/kbd_scancode_decoder.sv
// PS/2 scancode bytes -> ASCII FIFO; char written 2 cycles after the synchronised ready edge (CharValid in k+2).
// No backpressure to the keyboard: a character arriving while the FIFO is full is dropped and Overflow latches.
module kbd_scancode_decoder #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] ParallelData,
    input  logic       ParallelDataReady,
    input  logic       RdEn,
    output logic [7:0] CharData,
    output logic       CharValid,
    output logic       FifoFull,
    output logic       Overflow,
    output logic       ShiftActive,
    output logic       CapsLock
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    // Returns {valid, ascii}; valid=0 for codes with no printable mapping.
    function automatic logic [8:0] map_code(input logic [7:0] code, input logic shift, input logic caps);
        logic [7:0] lc;
        logic [7:0] dn;
        logic [7:0] ds;
        logic [8:0] res;
        lc  = 8'h00;
        dn  = 8'h00;
        ds  = 8'h00;
        res = 9'h000;
        case (code)
            8'h1C: lc = 8'h61;  8'h32: lc = 8'h62;  8'h21: lc = 8'h63;  8'h23: lc = 8'h64;
            8'h24: lc = 8'h65;  8'h2B: lc = 8'h66;  8'h34: lc = 8'h67;  8'h33: lc = 8'h68;
            8'h43: lc = 8'h69;  8'h3B: lc = 8'h6A;  8'h42: lc = 8'h6B;  8'h4B: lc = 8'h6C;
            8'h3A: lc = 8'h6D;  8'h31: lc = 8'h6E;  8'h44: lc = 8'h6F;  8'h4D: lc = 8'h70;
            8'h15: lc = 8'h71;  8'h2D: lc = 8'h72;  8'h1B: lc = 8'h73;  8'h2C: lc = 8'h74;
            8'h3C: lc = 8'h75;  8'h2A: lc = 8'h76;  8'h1D: lc = 8'h77;  8'h22: lc = 8'h78;
            8'h35: lc = 8'h79;  8'h1A: lc = 8'h7A;
            8'h16: begin dn = 8'h31; ds = 8'h21; end
            8'h1E: begin dn = 8'h32; ds = 8'h40; end
            8'h26: begin dn = 8'h33; ds = 8'h23; end
            8'h25: begin dn = 8'h34; ds = 8'h24; end
            8'h2E: begin dn = 8'h35; ds = 8'h25; end
            8'h36: begin dn = 8'h36; ds = 8'h5E; end
            8'h3D: begin dn = 8'h37; ds = 8'h26; end
            8'h3E: begin dn = 8'h38; ds = 8'h2A; end
            8'h46: begin dn = 8'h39; ds = 8'h28; end
            8'h45: begin dn = 8'h30; ds = 8'h29; end
            8'h29: res = {1'b1, 8'h20};
            8'h5A: res = {1'b1, 8'h0D};
            8'h66: res = {1'b1, 8'h08};
            8'h0D: res = {1'b1, 8'h09};
            default: res = 9'h000;
        endcase
        if (lc != 8'h00) begin
            res = {1'b1, (shift ^ caps) ? (lc - 8'h20) : lc};
        end else if (dn != 8'h00) begin
            res = {1'b1, shift ? ds : dn};
        end
        return res;
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   evt;
    logic                   evt_q;
    logic [7:0]             byte_q;

    assign evt = sync_q[SYNC_STAGES-1] & ~hist_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            evt_q  <= 1'b0;
            byte_q <= 8'h00;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ParallelDataReady};
            hist_q <= sync_q[SYNC_STAGES-1];
            evt_q  <= evt;
            if (evt) begin
                byte_q <= ParallelData;
            end
        end
    end

    state_t     state_q, state_d;
    logic       lshift_q, lshift_d;
    logic       rshift_q, rshift_d;
    logic       caps_q, caps_d;
    logic       push;
    logic [7:0] push_dat;
    logic [8:0] mapped;

    // Decode uses the modifier state from before this byte.
    assign mapped = map_code(byte_q, lshift_q | rshift_q, caps_q);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= IDLE;
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
            caps_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
            caps_q   <= caps_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        caps_d   = caps_q;
        push     = 1'b0;
        push_dat = 8'h00;
        if (evt_q) begin
            unique case (state_q)
                IDLE: begin
                    if (byte_q == 8'hE0) begin
                        state_d = EXT;
                    end else if (byte_q == 8'hF0) begin
                        state_d = BRK;
                    end else if (byte_q == 8'h12) begin
                        lshift_d = 1'b1;
                    end else if (byte_q == 8'h59) begin
                        rshift_d = 1'b1;
                    end else if (byte_q == 8'h58) begin
                        caps_d = ~caps_q;
                    end else if (mapped[8]) begin
                        push     = 1'b1;
                        push_dat = mapped[7:0];
                    end
                end
                BRK: begin
                    state_d = IDLE;
                    if (byte_q == 8'h12) begin
                        lshift_d = 1'b0;
                    end else if (byte_q == 8'h59) begin
                        rshift_d = 1'b0;
                    end
                end
                EXT: begin
                    if (byte_q == 8'hF0) begin
                        state_d = EXT_BRK;
                    end else begin
                        state_d = IDLE;
                        if (byte_q == 8'h5A) begin
                            push     = 1'b1;
                            push_dat = 8'h0D;
                        end
                    end
                end
                EXT_BRK: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic        full;
    logic        pop;
    logic        wr_en;
    logic        ovf_q;

    assign full  = (count == DEPTH_C);
    assign pop   = RdEn && (count != '0);
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !wr_en) begin
                count <= count - 1'b1;
            end
            if (push && full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign CharValid   = (count != '0);
    assign CharData    = CharValid ? mem[rd_ptr] : 8'h00;
    assign FifoFull    = full;
    assign Overflow    = ovf_q;
    assign ShiftActive = lshift_q | rshift_q;
    assign CapsLock    = caps_q;

endmodule
